// File: rtl/calc_display_driver.sv
// Purpose: assemble the calculator core's serial digit stream into an 8-digit
//          frame, commit it atomically on ready, and scan it onto a
//          multiplexed common-anode seven-segment display with optional
//          leading-zero blanking and a latched error screen.
// Ports:
//   clock   in  1  system clock, rising edge
//   reset   in  1  asynchronous active-high reset
//   status  in  2  core status: 00 error, 01 busy, 1x ready
//   data    in  4  digit value for position pos (0..9 BCD, 10..15 non-digit)
//   pos     in  4  digit position, 0 = least significant, 8..15 ignored
//   an      out 8  anode enables, active-low, one-hot-low while scanning
//   seg     out 7  segments {g,f,e,d,c,b,a}, active-low
//   dp      out 1  decimal point, active-low, always off
module calc_display_driver #(
    parameter int unsigned SCAN_DIV    = 50000,
    parameter bit          BLANK_ZEROS = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] status,
    input  logic [3:0] data,
    input  logic [3:0] pos,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;

    logic [7:0][3:0] shadow_q, shadow_d;
    logic [7:0][3:0] frame_q,  frame_d;
    logic [PW-1:0]   presc_q,  presc_d;
    logic [2:0]      scan_idx_q, scan_idx_d;
    logic            err_q,    err_d;
    logic            prev_ready_q, ready_c;
    logic [7:0]      an_q,     an_d;
    logic [6:0]      seg_q,    seg_d;
    logic            dp_q;

    logic [7:0]      live_c;
    logic [3:0]      cur_digit_c;

    // BCD to active-low segment pattern; non-digit codes show a dash
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        case (v)
            4'd0:    bcd_to_seg = 7'h40;
            4'd1:    bcd_to_seg = 7'h79;
            4'd2:    bcd_to_seg = 7'h24;
            4'd3:    bcd_to_seg = 7'h30;
            4'd4:    bcd_to_seg = 7'h19;
            4'd5:    bcd_to_seg = 7'h12;
            4'd6:    bcd_to_seg = 7'h02;
            4'd7:    bcd_to_seg = 7'h78;
            4'd8:    bcd_to_seg = 7'h00;
            4'd9:    bcd_to_seg = 7'h10;
            default: bcd_to_seg = SEG_DASH;
        endcase
    endfunction

    assign ready_c = status[1];

    // Capture, commit, error latch and scan timing
    always_comb begin
        shadow_d   = shadow_q;
        frame_d    = frame_q;
        err_d      = err_q;
        presc_d    = presc_q + PW'(1);
        scan_idx_d = scan_idx_q;

        if (!ready_c && !pos[3]) begin
            shadow_d[pos[2:0]] = data;
        end
        if (ready_c && !prev_ready_q) begin
            frame_d = shadow_q;
        end
        if (status == 2'b00) begin
            err_d = 1'b1;
        end
        if (presc_q == PRESC_MAX) begin
            presc_d    = '0;
            scan_idx_d = scan_idx_q + 3'd1;
        end
    end

    // live_c[i] is set when some digit at or above i is non-zero (suffix OR)
    always_comb begin
        live_c = '0;
        live_c[7] = |frame_q[7];
        for (int i = 6; i >= 0; i--) begin
            live_c[i] = live_c[i+1] | (|frame_q[i]);
        end
    end

    assign cur_digit_c = frame_q[scan_idx_q];

    // Output pattern for the digit currently selected by scan_idx
    always_comb begin
        an_d  = ~(8'b1 << scan_idx_q);
        seg_d = bcd_to_seg(cur_digit_c);
        if (err_q) begin
            case (scan_idx_q)
                3'd2:       seg_d = SEG_E;
                3'd1, 3'd0: seg_d = SEG_R;
                default:    seg_d = SEG_BLANK;
            endcase
        end else if (BLANK_ZEROS && (scan_idx_q != 3'd0) && !live_c[scan_idx_q]) begin
            seg_d = SEG_BLANK;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow_q     <= '0;
            frame_q      <= '0;
            presc_q      <= '0;
            scan_idx_q   <= '0;
            err_q        <= 1'b0;
            prev_ready_q <= 1'b0;
            an_q         <= 8'hFF;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
        end else begin
            shadow_q     <= shadow_d;
            frame_q      <= frame_d;
            presc_q      <= presc_d;
            scan_idx_q   <= scan_idx_d;
            err_q        <= err_d;
            prev_ready_q <= ready_c;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= 1'b1;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_calc_display_driver.sv
// Self-checking bench for calc_display_driver: two instances (leading-zero
// blanking on and off) share stimulus; a reference model predicts each scanned
// digit and the expectations are queued then compared as the scan comes round.
module tb_calc_display_driver;

    localparam int unsigned DIV = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] status;
    logic [3:0] data;
    logic [3:0] pos;
    logic [7:0] an,  an_nb;
    logic [6:0] seg, seg_nb;
    logic       dp,  dp_nb;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic [6:0] seg_nb;
    } exp_t;

    exp_t sb_q[$];

    // reference model state
    logic [3:0] m_shadow [8];
    logic [3:0] m_frame  [8];
    logic       m_prev;
    logic       m_err;

    calc_display_driver #(.SCAN_DIV(DIV), .BLANK_ZEROS(1'b1)) dut (
        .clock(clock), .reset(reset), .status(status), .data(data), .pos(pos),
        .an(an), .seg(seg), .dp(dp)
    );

    calc_display_driver #(.SCAN_DIV(DIV), .BLANK_ZEROS(1'b0)) dut_nb (
        .clock(clock), .reset(reset), .status(status), .data(data), .pos(pos),
        .an(an_nb), .seg(seg_nb), .dp(dp_nb)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] ref_dec(input logic [3:0] v);
        case (v)
            4'd0: return 7'h40;  4'd1: return 7'h79;
            4'd2: return 7'h24;  4'd3: return 7'h30;
            4'd4: return 7'h19;  4'd5: return 7'h12;
            4'd6: return 7'h02;  4'd7: return 7'h78;
            4'd8: return 7'h00;  4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    function automatic logic [6:0] ref_seg(input int i, input bit blank);
        bit all_zero;
        if (m_err) begin
            if (i == 2) return 7'h06;
            if (i < 2)  return 7'h2F;
            return 7'h7F;
        end
        all_zero = 1'b1;
        for (int j = i; j < 8; j++) if (m_frame[j] != 4'd0) all_zero = 1'b0;
        if (blank && i > 0 && all_zero) return 7'h7F;
        return ref_dec(m_frame[i]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) begin
            m_shadow[k] = 4'd0;
            m_frame[k]  = 4'd0;
        end
        m_prev = 1'b0;
        m_err  = 1'b0;
    endtask

    // drive one cycle of stream input and advance the model to match
    task automatic drive(input logic [1:0] st, input logic [3:0] d, input logic [3:0] p);
        @(negedge clock);
        status = st; data = d; pos = p;
        if (st == 2'b00) m_err = 1'b1;
        if (st[1] && !m_prev) for (int k = 0; k < 8; k++) m_frame[k] = m_shadow[k];
        if (!st[1] && p < 4'd8) m_shadow[p[2:0]] = d;
        m_prev = st[1];
    endtask

    // queue one full scan of expectations, then compare digit by digit
    task automatic check_scan(input string tag);
        int budget;
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.an     = ~(8'b1 << i);
            e.seg    = ref_seg(i, 1'b1);
            e.seg_nb = ref_seg(i, 1'b0);
            sb_q.push_back(e);
        end
        repeat (3) @(negedge clock);
        budget = 0;
        while (an !== 8'hFE && budget < 64) begin
            @(negedge clock);
            budget++;
        end
        n_checks++;
        if (an !== 8'hFE) begin
            n_fail++;
            $display("FAIL %s scan_sync: an=%h required FE", tag, an);
            sb_q.delete();
            return;
        end
        for (int i = 0; i < 8; i++) begin
            e = sb_q.pop_front();
            n_checks++;
            if (an !== e.an || an_nb !== e.an) begin
                n_fail++;
                $display("FAIL %s an[%0d]: got %h/%h required %h", tag, i, an, an_nb, e.an);
            end
            n_checks++;
            if (seg !== e.seg) begin
                n_fail++;
                $display("FAIL %s seg[%0d]: got %h required %h", tag, i, seg, e.seg);
            end
            n_checks++;
            if (seg_nb !== e.seg_nb) begin
                n_fail++;
                $display("FAIL %s seg_nb[%0d]: got %h required %h", tag, i, seg_nb, e.seg_nb);
            end
            n_checks++;
            if (dp !== 1'b1 || dp_nb !== 1'b1) begin
                n_fail++;
                $display("FAIL %s dp[%0d]: got %b/%b required 1", tag, i, dp, dp_nb);
            end
            repeat (DIV) @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; status = 2'b10; data = 4'd0; pos = 4'd0;
        model_reset();
        repeat (3) @(negedge clock);
        n_checks++;
        if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 ||
            an_nb !== 8'hFF || seg_nb !== 7'h7F || dp_nb !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_values: an=%h seg=%h dp=%b required FF 7F 1", an, seg, dp);
        end
        reset = 1'b0;
        @(negedge clock);
        m_prev = 1'b1;
        n_checks++;
        if (an !== 8'hFE || seg !== 7'h40 || seg_nb !== 7'h40) begin
            n_fail++;
            $display("FAIL first_step: an=%h seg=%h seg_nb=%h required FE 40 40", an, seg, seg_nb);
        end
        check_scan("zero_frame");
    endtask

    task automatic test_stream_127();
        drive(2'b01, 4'd7, 4'd0);
        drive(2'b01, 4'd2, 4'd1);
        drive(2'b01, 4'd1, 4'd2);
        drive(2'b01, 4'd9, 4'd9);   // out-of-range position is ignored
        for (int p = 3; p < 8; p++) drive(2'b01, 4'd0, 4'(p));
        drive(2'b10, 4'd0, 4'd0);
        check_scan("frame_127");
    endtask

    task automatic test_hold_busy();
        drive(2'b01, 4'd5, 4'd0);
        repeat (40) @(negedge clock);
        check_scan("busy_hold");
        drive(2'b10, 4'd0, 4'd0);
        check_scan("frame_125");
    endtask

    task automatic test_non_digit();
        drive(2'b01, 4'd11, 4'd3);
        for (int p = 0; p < 8; p++) if (p != 3) drive(2'b01, 4'd0, 4'(p));
        drive(2'b11, 4'd0, 4'd0);
        check_scan("dash_code");
    endtask

    task automatic test_error();
        drive(2'b00, 4'd0, 4'd8);
        drive(2'b10, 4'd0, 4'd0);
        check_scan("err_screen");
        drive(2'b01, 4'd3, 4'd0);   // later frames are ignored while err is latched
        drive(2'b10, 4'd0, 4'd0);
        check_scan("err_persist");
        @(negedge clock);
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: an=%h seg=%h dp=%b required FF 7F 1", an, seg, dp);
        end
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        m_prev = 1'b1;
        check_scan("after_reset");
    endtask

    initial begin
        test_reset();
        test_stream_127();
        test_hold_busy();
        test_non_digit();
        test_error();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
